md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the combinational ALU.
- Accepts one HI/LO operation per start pulse and holds busy for a fixed latency.
- The pipeline stalls any HI/LO instruction in decode while the unit is occupied.
- Owns the architectural HI and LO registers, which mfhi/mflo read.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family when enabled); must be >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: issue MDOp with operands A, B
- MDOp  input  4  operation code, defined in head.v
- A  input  32  rs operand (dividend, multiplicand, or mthi/mtlo data)
- B  input  32  rt operand (divisor, multiplier)
- busy  output  1  multi-cycle operation in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending result cleared; applies at the next edge even mid-operation, and the in-flight result is discarded.
- States: IDLE and RUN.
- IDLE + start + mult/multu/div/divu:
  - Compute the 64-bit result in the same cycle and latch it into pending {ph, pl}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- RUN: decrement counter each cycle. At counter==1: HI<=ph, LO<=pl, busy<=0, go to IDLE.
  - Net result: busy is high for exactly N cycles, and the new HI/LO are visible on the edge where busy falls.
- mult: signed 32x32, {HI,LO}=A*B. multu: unsigned.
- div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (B==0): HI<=A, LO<=32'hFFFFFFFF, with the same DIV_CYCLES latency; no trap.
- Signed overflow (div 0x80000000 / -1): LO=0x80000000, HI=0.
- mthi/mtlo with start in IDLE: HI<=A (or LO<=A) on the next edge; busy never asserts.
- start while busy=1 is ignored, with no state change; the hazard unit must prevent it by stalling on (start | busy).
- Unknown MDOp with start: no effect.
- HI/LO never change except as above; mfhi/mflo sampled while busy return the old values.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MDOp also decodes madd, maddu, msub, msubu.
  - {HI,LO} <= {HI,LO} ± product (signed or unsigned per op), modulo 2^64.
  - Accumulation uses HI/LO as captured at start; latency MULT_CYCLES.
- Undefined: those codes are treated as unknown (no effect).

Decomposition:
- head.v holds the MDOp codes: `MDU_mult, `MDU_multu, `MDU_div, `MDU_divu, `MDU_mthi, `MDU_mtlo, and `MDU_madd/`MDU_maddu/`MDU_msub/`MDU_msubu.
- head.v also holds default latency constants. Everything else is local.
- No sub-module: the arithmetic uses native operators and the control is a single counter.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=2 -> busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE when busy falls, and HI/LO still 0 during busy.
- multu A=0xFFFFFFFF B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3, HI=1.
- divu A=0x1234 B=0 -> LO=0xFFFFFFFF, HI=0x1234; then mthi A=0xAAAA5555 -> HI updated the next cycle, busy stays 0.
- mult issued, second start (div) pulsed at busy cycle 2 -> ignored; only the mult result lands at cycle 5.
- div issued, reset asserted at busy cycle 4 -> next cycle busy=0, HI=LO=0, and no late write occurs.
- MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, then maddu A=1 B=1 -> HI=1, LO=0.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp codes, default latencies and divide helpers.
// The madd/maddu/msub/msubu codes only take effect in md_unit when MDU_MADD_EN is defined.
package md_unit_pkg;

    // MDOp encodings; 4'd0 and 4'd11..4'd15 are unused and decode as no-ops.
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam int MDU_MULT_CYCLES_DEFAULT = 5;
    localparam int MDU_DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    // What an accepted start does: launch a timed operation or write HI/LO directly.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_LONG,
        OP_MTHI,
        OP_MTLO
    } md_kind_e;

    // Signed divide on magnitudes: quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    // Returns {remainder, quotient}; the caller handles a zero divisor.
    function automatic logic [63:0] signed_divide(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] uq;
        logic [31:0] ur;
        logic [31:0] q;
        logic [31:0] r;
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        uq    = mag_a / mag_b;
        ur    = mag_a % mag_b;
        q     = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        r     = a[31] ? (~ur + 32'd1) : ur;
        return {r, q};
    endfunction

    function automatic logic [63:0] unsigned_divide(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is computed at issue and released after a fixed latency.
// Define MDU_MADD_EN to also decode madd/maddu/msub/msubu (accumulate into HI/LO captured at issue).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    md_state_e        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      ph_reg;
    logic [31:0]      pl_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic             busy_reg;

    md_kind_e         kind_next;
    logic [63:0]      result_next;
    logic [CNT_W-1:0] cnt_load_next;

    // Full 64-bit products; sign-extending before a 64x64 multiply gives the signed product mod 2^64.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Decode the operation presented with start into its pending result and latency.
    always_comb begin
        kind_next     = OP_NONE;
        result_next   = 64'd0;
        cnt_load_next = '0;
        case (MDOp)
            MDU_MULT: begin
                kind_next     = OP_LONG;
                result_next   = prod_s;
                cnt_load_next = MULT_CNT;
            end
            MDU_MULTU: begin
                kind_next     = OP_LONG;
                result_next   = prod_u;
                cnt_load_next = MULT_CNT;
            end
            MDU_DIV: begin
                kind_next     = OP_LONG;
                result_next   = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : signed_divide(A, B);
                cnt_load_next = DIV_CNT;
            end
            MDU_DIVU: begin
                kind_next     = OP_LONG;
                result_next   = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : unsigned_divide(A, B);
                cnt_load_next = DIV_CNT;
            end
            MDU_MTHI: kind_next = OP_MTHI;
            MDU_MTLO: kind_next = OP_MTLO;
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                kind_next     = OP_LONG;
                result_next   = {hi_reg, lo_reg} + prod_s;
                cnt_load_next = MULT_CNT;
            end
            MDU_MADDU: begin
                kind_next     = OP_LONG;
                result_next   = {hi_reg, lo_reg} + prod_u;
                cnt_load_next = MULT_CNT;
            end
            MDU_MSUB: begin
                kind_next     = OP_LONG;
                result_next   = {hi_reg, lo_reg} - prod_s;
                cnt_load_next = MULT_CNT;
            end
            MDU_MSUBU: begin
                kind_next     = OP_LONG;
                result_next   = {hi_reg, lo_reg} - prod_u;
                cnt_load_next = MULT_CNT;
            end
`endif
            default: kind_next = OP_NONE;
        endcase
    end

    // Single controller: start is only honoured in IDLE; HI/LO change solely on completion or mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ph_reg    <= 32'd0;
            pl_reg    <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        case (kind_next)
                            OP_LONG: begin
                                ph_reg    <= result_next[63:32];
                                pl_reg    <= result_next[31:0];
                                cnt_reg   <= cnt_load_next;
                                busy_reg  <= 1'b1;
                                state_reg <= ST_RUN;
                            end
                            OP_MTHI: hi_reg <= A;
                            OP_MTLO: lo_reg <= A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    cnt_reg <= cnt_reg - LAST_CNT;
                    if (cnt_reg == LAST_CNT) begin
                        hi_reg    <= ph_reg;
                        lo_reg    <= pl_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized operations against an arithmetic model.
// Define MDU_MADD_EN for both bench and RTL to exercise the accumulate operations.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    // Model of the architectural registers.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: new {HI,LO} for an operation, computed with 64-bit integer arithmetic.
    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] hi,
                                                 input logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint          sq;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {hi, lo};
        case (op)
            MDU_MULT:  return sa * sb;
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            MDU_MTHI:  return {a, lo};
            MDU_MTLO:  return {hi, a};
`ifdef MDU_MADD_EN
            MDU_MADD:  return acc + 64'(sa * sb);
            MDU_MADDU: return acc + ua * ub;
            MDU_MSUB:  return acc - 64'(sa * sb);
            MDU_MSUBU: return acc - ua * ub;
`endif
            default:   return {hi, lo};
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return MULT_N;
            MDU_DIV, MDU_DIVU:   return DIV_N;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return MULT_N;
`endif
            default:             return 0;
        endcase
    endfunction

    // Issue one op (entered and left at a negedge); reports busy length and whether HI/LO held during busy.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0    = HI;
        l0    = LO;
        start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        held  = 1'b1;
        while (busy && cyc < 1000) begin
            if (HI !== h0 || LO !== l0) held = 1'b0;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        MDOp  = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b HI=%h LO=%h, required busy=0 HI=0 LO=0", busy, HI, LO);
        end
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);
    endtask

    // Run one op, then compare latency, HI/LO hold during busy, and final HI/LO against the model.
    task automatic test_op(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        int          cyc;
        bit          held;
        logic [63:0] exp;
        int          exp_cyc;
        exp     = model_result(op, a, b, m_hi, m_lo);
        exp_cyc = model_latency(op);
        do_op(op, a, b, cyc, held);
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: busy cycles=%0d, required %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s hold: HI/LO changed while busy, required old HI=%h LO=%h", name, m_hi, m_lo);
        end
        checks++;
        if (HI !== exp[63:32] || LO !== exp[31:0]) begin
            errors++;
            $display("FAIL %s result: A=%h B=%h HI=%h LO=%h, required HI=%h LO=%h",
                     name, a, b, HI, LO, exp[63:32], exp[31:0]);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        $display("op %s A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", name, a, b, HI, LO, cyc);
    endtask

    task automatic test_directed;
        test_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult const: HI=%h LO=%h, required HI=ffffffff LO=fffffffe", HI, LO);
        end
        test_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu const: HI=%h LO=%h, required HI=00000001 LO=fffffffe", HI, LO);
        end
        test_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div const: HI=%h LO=%h, required HI=ffffffff LO=fffffffd", HI, LO);
        end
        test_op("divu", MDU_DIVU, 32'd7, 32'd2);
        checks++;
        if (HI !== 32'd1 || LO !== 32'd3) begin
            errors++;
            $display("FAIL divu const: HI=%h LO=%h, required HI=00000001 LO=00000003", HI, LO);
        end
        test_op("divu_zero", MDU_DIVU, 32'h0000_1234, 32'd0);
        checks++;
        if (HI !== 32'h0000_1234 || LO !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_zero const: HI=%h LO=%h, required HI=00001234 LO=ffffffff", HI, LO);
        end
        test_op("mthi", MDU_MTHI, 32'hAAAA_5555, 32'd0);
        checks++;
        if (HI !== 32'hAAAA_5555 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi const: HI=%h busy=%b, required HI=aaaa5555 busy=0", HI, busy);
        end
        test_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf const: HI=%h LO=%h, required HI=00000000 LO=80000000", HI, LO);
        end
        test_op("unknown", 4'd15, 32'h1111_1111, 32'h2222_2222);
    endtask

    // A second start at busy cycle 2 must be ignored.
    task automatic test_ignore_start;
        int          cyc;
        logic [63:0] exp;
        exp   = model_result(MDU_MULT, 32'h0001_0003, 32'h0002_0005, m_hi, m_lo);
        start = 1'b1;
        MDOp  = MDU_MULT;
        A     = 32'h0001_0003;
        B     = 32'h0002_0005;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            if (cyc == 2) begin
                start = 1'b1;
                MDOp  = MDU_DIV;
                A     = 32'd100;
                B     = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (cyc != MULT_N) begin
            errors++;
            $display("FAIL ignore latency: busy cycles=%0d, required %0d", cyc, MULT_N);
        end
        repeat (DIV_N + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== exp[63:32] || LO !== exp[31:0]) begin
            errors++;
            $display("FAIL ignore result: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
                     busy, HI, LO, exp[63:32], exp[31:0]);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        $display("op ignore_start mult then div at busy cycle 2 -> HI=%h LO=%h", HI, LO);
    endtask

    // Reset at busy cycle 4 of a divide must discard the pending result.
    task automatic test_reset_mid;
        start = 1'b1;
        MDOp  = MDU_DIV;
        A     = 32'd1000;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b HI=%h LO=%h, required busy=0 HI=0 LO=0", busy, HI, LO);
        end
        repeat (DIV_N + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid late: busy=%b HI=%h LO=%h, required busy=0 HI=0 LO=0", busy, HI, LO);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        $display("op reset_mid div aborted -> HI=%h LO=%h busy=%b", HI, LO, busy);
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
            op = 4'($urandom_range(1, 10));
`else
            op = 4'($urandom_range(0, 7));
`endif
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            test_op("random", op, a, b);
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        test_op("mthi0", MDU_MTHI, 32'd0, 32'd0);
        test_op("mtloF", MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        test_op("maddu", MDU_MADDU, 32'd1, 32'd1);
        checks++;
        if (HI !== 32'd1 || LO !== 32'd0) begin
            errors++;
            $display("FAIL maddu const: HI=%h LO=%h, required HI=00000001 LO=00000000", HI, LO);
        end
        test_op("msub", MDU_MSUB, 32'hFFFF_FFFE, 32'd3);
        test_op("madd", MDU_MADD, 32'h7FFF_FFFF, 32'h8000_0000);
        test_op("msubu", MDU_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_directed;
        test_ignore_start;
        test_reset_mid;
`ifdef MDU_MADD_EN
        test_madd;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
